rvh_l1d_wb_arb: RTL and testbench

- Shares one private-cache→SCU evict/writeback channel pair (evict req + data) among N_BANK per-bank L1D eviction/writeback queues.
- Round-robin evict arbitration with a grant lock held until handshake.
- Independent round-robin data arbitration.
- Per-bank outstanding-writeback throttling.
- Routes SCU responses back to the owning bank by the bid field.
- Sits between the L1D bank writeback queues and the core's SCU tx/rx ports.

---
 rtl/rvh_l1d_wb_arb.sv | 258 +++++++++++++++++++++++++
 tb/tb_rvh_l1d_wb_arb.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvh_l1d_wb_arb.sv
// Shares one private-cache to SCU evict/writeback channel pair among N_BANK L1D banks.
// Optional: define RVH_L1D_WB_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module rvh_l1d_wb_arb #(
    parameter int N_BANK          = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter int BANK_ID_W       = $clog2(N_BANK),
    parameter int REQ_W           = 64,
    parameter int DATA_W          = 64,
    parameter int RESP_W          = 32,
    parameter int RESP_BID_LSB    = 0,
    parameter int RESP_RTYPE_LSB  = 8,
    parameter int RTYPE_W         = 4,
    parameter logic [RTYPE_W-1:0] RTYPE_WB_ACK = RTYPE_W'(6)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_BANK-1:0]               bank_evict_vld_i,
    input  logic [N_BANK-1:0][REQ_W-1:0]    bank_evict_i,
    output logic [N_BANK-1:0]               bank_evict_rdy_o,
    input  logic [N_BANK-1:0]               bank_data_vld_i,
    input  logic [N_BANK-1:0][DATA_W-1:0]   bank_data_i,
    output logic [N_BANK-1:0]               bank_data_rdy_o,
    output logic [N_BANK-1:0]               bank_resp_vld_o,
    output logic [RESP_W-1:0]               bank_resp_o,
    input  logic [N_BANK-1:0]               bank_resp_rdy_i,
    output logic                            pc_scu_evict_vld_o,
    output logic [REQ_W-1:0]                pc_scu_evict_o,
    input  logic                            pc_scu_evict_rdy_i,
    output logic                            pc_scu_data_vld_o,
    output logic [DATA_W-1:0]               pc_scu_data_o,
    input  logic                            pc_scu_data_rdy_i,
    input  logic                            scu_pc_resp_vld_i,
    input  logic [RESP_W-1:0]               scu_pc_resp_i,
    output logic                            scu_pc_resp_rdy_o,
    output logic [N_BANK-1:0][2:0]          outstanding_o
);

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

    // Returns {found, index} of the first requester at or after ptr, wrapping.
    function automatic logic [BANK_ID_W:0] rr_pick(input logic [N_BANK-1:0]    req,
                                                   input logic [BANK_ID_W-1:0] ptr);
        logic [BANK_ID_W:0]   res;
        logic [BANK_ID_W-1:0] idx;
        res = '0;
        for (int k = N_BANK - 1; k >= 0; k--) begin
            idx = ptr + BANK_ID_W'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    logic [N_BANK-1:0][2:0]  cnt_q;
    logic [N_BANK-1:0]       ev_elig;
    logic [N_BANK-1:0]       ev_inc;
    logic [N_BANK-1:0]       rsp_dec;
    logic [BANK_ID_W:0]      ev_pick;
    logic [BANK_ID_W:0]      dt_pick;
    arb_state_e              ev_state_q;
    arb_state_e              ev_state_d;
    arb_state_e              dt_state_q;
    arb_state_e              dt_state_d;
    logic [BANK_ID_W-1:0]    ev_lock_q;
    logic [BANK_ID_W-1:0]    dt_lock_q;
    logic [BANK_ID_W-1:0]    ev_sel;
    logic [BANK_ID_W-1:0]    dt_sel;
    logic                    ev_vld;
    logic                    dt_vld;
    logic                    ev_hs;
    logic                    dt_hs;
    logic [BANK_ID_W-1:0]    resp_tgt;
    logic                    resp_is_ack;
    logic                    resp_hs;

    always_comb begin
        ev_elig = '0;
        for (int i = 0; i < N_BANK; i++) begin
            ev_elig[i] = bank_evict_vld_i[i] & (cnt_q[i] < MAX_CNT);
        end
    end

`ifdef RVH_L1D_WB_ARB_FIXED_PRIO_EN
    always_comb begin
        ev_pick = rr_pick(ev_elig, '0);
        dt_pick = rr_pick(bank_data_vld_i, '0);
    end
`else
    logic [BANK_ID_W-1:0] ev_ptr_q;
    logic [BANK_ID_W-1:0] dt_ptr_q;

    always_comb begin
        ev_pick = rr_pick(ev_elig, ev_ptr_q);
        dt_pick = rr_pick(bank_data_vld_i, dt_ptr_q);
    end

    // Pointers move just past the bank that completed a handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ev_ptr_q <= '0;
            dt_ptr_q <= '0;
        end else begin
            if (ev_hs) begin
                ev_ptr_q <= ev_sel + 1'b1;
            end
            if (dt_hs) begin
                dt_ptr_q <= dt_sel + 1'b1;
            end
        end
    end
`endif

    // Evict arbiter: state register, next state, outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ev_state_q <= ARB_IDLE;
            ev_lock_q  <= '0;
        end else begin
            ev_state_q <= ev_state_d;
            if (ev_state_q == ARB_IDLE && ev_vld && !ev_hs) begin
                ev_lock_q <= ev_sel;
            end
        end
    end

    always_comb begin
        ev_state_d = ev_state_q;
        case (ev_state_q)
            ARB_IDLE: begin
                if (ev_pick[BANK_ID_W] && !pc_scu_evict_rdy_i) begin
                    ev_state_d = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                if (pc_scu_evict_rdy_i || !bank_evict_vld_i[ev_lock_q]) begin
                    ev_state_d = ARB_IDLE;
                end
            end
            default: ev_state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        ev_sel = ev_pick[BANK_ID_W-1:0];
        ev_vld = ev_pick[BANK_ID_W];
        if (ev_state_q == ARB_LOCKED) begin
            ev_sel = ev_lock_q;
            ev_vld = bank_evict_vld_i[ev_lock_q];
        end
        ev_hs              = ev_vld & pc_scu_evict_rdy_i;
        pc_scu_evict_vld_o = ev_vld;
        pc_scu_evict_o     = bank_evict_i[ev_sel];
        bank_evict_rdy_o   = '0;
        if (ev_hs) begin
            bank_evict_rdy_o[ev_sel] = 1'b1;
        end
    end

    // Data arbiter: same lock scheme, no outstanding gating.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dt_state_q <= ARB_IDLE;
            dt_lock_q  <= '0;
        end else begin
            dt_state_q <= dt_state_d;
            if (dt_state_q == ARB_IDLE && dt_vld && !dt_hs) begin
                dt_lock_q <= dt_sel;
            end
        end
    end

    always_comb begin
        dt_state_d = dt_state_q;
        case (dt_state_q)
            ARB_IDLE: begin
                if (dt_pick[BANK_ID_W] && !pc_scu_data_rdy_i) begin
                    dt_state_d = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                if (pc_scu_data_rdy_i || !bank_data_vld_i[dt_lock_q]) begin
                    dt_state_d = ARB_IDLE;
                end
            end
            default: dt_state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        dt_sel = dt_pick[BANK_ID_W-1:0];
        dt_vld = dt_pick[BANK_ID_W];
        if (dt_state_q == ARB_LOCKED) begin
            dt_sel = dt_lock_q;
            dt_vld = bank_data_vld_i[dt_lock_q];
        end
        dt_hs             = dt_vld & pc_scu_data_rdy_i;
        pc_scu_data_vld_o = dt_vld;
        pc_scu_data_o     = bank_data_i[dt_sel];
        bank_data_rdy_o   = '0;
        if (dt_hs) begin
            bank_data_rdy_o[dt_sel] = 1'b1;
        end
    end

    // Responses route by the low bid bits; the I$ msb is not decoded.
    always_comb begin
        resp_tgt          = scu_pc_resp_i[RESP_BID_LSB +: BANK_ID_W];
        resp_is_ack       = (scu_pc_resp_i[RESP_RTYPE_LSB +: RTYPE_W] == RTYPE_WB_ACK);
        scu_pc_resp_rdy_o = bank_resp_rdy_i[resp_tgt];
        resp_hs           = scu_pc_resp_vld_i & scu_pc_resp_rdy_o;
        bank_resp_o       = scu_pc_resp_i;
        bank_resp_vld_o   = '0;
        if (scu_pc_resp_vld_i) begin
            bank_resp_vld_o[resp_tgt] = 1'b1;
        end
    end

    always_comb begin
        ev_inc  = '0;
        rsp_dec = '0;
        for (int i = 0; i < N_BANK; i++) begin
            ev_inc[i]  = ev_hs & (ev_sel == BANK_ID_W'(i));
            rsp_dec[i] = resp_hs & resp_is_ack & (resp_tgt == BANK_ID_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < N_BANK; i++) begin
                if (ev_inc[i] && !rsp_dec[i]) begin
                    cnt_q[i] <= cnt_q[i] + 3'd1;
                end else if (rsp_dec[i] && !ev_inc[i] && cnt_q[i] != 3'd0) begin
                    cnt_q[i] <= cnt_q[i] - 3'd1;
                end
            end
        end
    end

    assign outstanding_o = cnt_q;

`ifndef SYNTHESIS
    a_evict_hold: assert property (@(posedge clk) disable iff (!rst)
        (ev_state_q == ARB_LOCKED) |-> bank_evict_vld_i[ev_lock_q]);
    a_data_hold: assert property (@(posedge clk) disable iff (!rst)
        (dt_state_q == ARB_LOCKED) |-> bank_data_vld_i[dt_lock_q]);
    a_ack_underflow: assert property (@(posedge clk) disable iff (!rst)
        !(resp_hs && resp_is_ack && cnt_q[resp_tgt] == 3'd0));
`endif

endmodule

// File: tb/tb_rvh_l1d_wb_arb.sv
// Randomized scoreboard bench for rvh_l1d_wb_arb against a bank-level arbitration model.
module tb_rvh_l1d_wb_arb;

    localparam int N_BANK  = 4;
    localparam int MAX_OUT = 2;
    localparam int REQ_W   = 64;
    localparam int DATA_W  = 64;
    localparam int RESP_W  = 32;
    localparam logic [3:0] WB_ACK = 4'h6;

    logic                          clk;
    logic                          rst;
    logic [N_BANK-1:0]             bank_evict_vld;
    logic [N_BANK-1:0][REQ_W-1:0]  bank_evict;
    logic [N_BANK-1:0]             bank_evict_rdy;
    logic [N_BANK-1:0]             bank_data_vld;
    logic [N_BANK-1:0][DATA_W-1:0] bank_data;
    logic [N_BANK-1:0]             bank_data_rdy;
    logic [N_BANK-1:0]             bank_resp_vld;
    logic [RESP_W-1:0]             bank_resp;
    logic [N_BANK-1:0]             bank_resp_rdy;
    logic                          pc_scu_evict_vld;
    logic [REQ_W-1:0]              pc_scu_evict;
    logic                          pc_scu_evict_rdy;
    logic                          pc_scu_data_vld;
    logic [DATA_W-1:0]             pc_scu_data;
    logic                          pc_scu_data_rdy;
    logic                          scu_pc_resp_vld;
    logic [RESP_W-1:0]             scu_pc_resp;
    logic                          scu_pc_resp_rdy;
    logic [N_BANK-1:0][2:0]        outstanding;

    rvh_l1d_wb_arb #(
        .N_BANK          (N_BANK),
        .MAX_OUTSTANDING (MAX_OUT),
        .REQ_W           (REQ_W),
        .DATA_W          (DATA_W),
        .RESP_W          (RESP_W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .bank_evict_vld_i   (bank_evict_vld),
        .bank_evict_i       (bank_evict),
        .bank_evict_rdy_o   (bank_evict_rdy),
        .bank_data_vld_i    (bank_data_vld),
        .bank_data_i        (bank_data),
        .bank_data_rdy_o    (bank_data_rdy),
        .bank_resp_vld_o    (bank_resp_vld),
        .bank_resp_o        (bank_resp),
        .bank_resp_rdy_i    (bank_resp_rdy),
        .pc_scu_evict_vld_o (pc_scu_evict_vld),
        .pc_scu_evict_o     (pc_scu_evict),
        .pc_scu_evict_rdy_i (pc_scu_evict_rdy),
        .pc_scu_data_vld_o  (pc_scu_data_vld),
        .pc_scu_data_o      (pc_scu_data),
        .pc_scu_data_rdy_i  (pc_scu_data_rdy),
        .scu_pc_resp_vld_i  (scu_pc_resp_vld),
        .scu_pc_resp_i      (scu_pc_resp),
        .scu_pc_resp_rdy_o  (scu_pc_resp_rdy),
        .outstanding_o      (outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Expected payloads per bank, pushed when a bank starts presenting a request.
    logic [REQ_W-1:0]  ev_q [N_BANK][$];
    logic [DATA_W-1:0] dt_q [N_BANK][$];

    // Reference model state.
    bit mon_en = 1'b0;
    int m_cnt [N_BANK];
    int m_ev_cur = -1;
    int m_ev_ptr = 0;
    int m_dt_cur = -1;
    int m_dt_ptr = 0;

    // Driver-side bookkeeping of accepted evicts not yet acknowledged.
    int drv_cnt [N_BANK];
    logic [N_BANK-1:0] ev_hs_obs;
    logic [N_BANK-1:0] dt_hs_obs;
    logic              rsp_hs_obs;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pick(input logic [N_BANK-1:0] req, input int ptr);
        for (int k = 0; k < N_BANK; k++) begin
            if (req[(ptr + k) % N_BANK]) return (ptr + k) % N_BANK;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        logic [N_BANK-1:0] elig;
        logic [N_BANK-1:0] exp_rdy;
        int                win;
        int                tgt;
        int                inc_b;
        int                dec_b;
        if (mon_en) begin
            inc_b = -1;
            dec_b = -1;
            for (int b = 0; b < N_BANK; b++) begin
                check($sformatf("outstanding[%0d]", b), 128'(outstanding[b]), 128'(m_cnt[b]));
                elig[b] = bank_evict_vld[b] && (m_cnt[b] < MAX_OUT);
            end

            win = (m_ev_cur >= 0) ? m_ev_cur : pick(elig, m_ev_ptr);
            exp_rdy = '0;
            if (win >= 0 && pc_scu_evict_rdy) exp_rdy[win] = 1'b1;
            check("evict_vld", 128'(pc_scu_evict_vld), 128'(win >= 0));
            check("evict_rdy", 128'(bank_evict_rdy), 128'(exp_rdy));
            if (win >= 0) begin
                if (ev_q[win].size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL evict_sb: bank %0d granted with no pending request", win);
                end else begin
                    check("evict_payload", 128'(pc_scu_evict), 128'(ev_q[win][0]));
                    if (pc_scu_evict_rdy) void'(ev_q[win].pop_front());
                end
            end
            if (win >= 0 && pc_scu_evict_rdy) begin
                inc_b = win;
                m_ev_cur = -1;
`ifndef RVH_L1D_WB_ARB_FIXED_PRIO_EN
                m_ev_ptr = (win + 1) % N_BANK;
`endif
            end else begin
                m_ev_cur = win;
            end

            win = (m_dt_cur >= 0) ? m_dt_cur : pick(bank_data_vld, m_dt_ptr);
            exp_rdy = '0;
            if (win >= 0 && pc_scu_data_rdy) exp_rdy[win] = 1'b1;
            check("data_vld", 128'(pc_scu_data_vld), 128'(win >= 0));
            check("data_rdy", 128'(bank_data_rdy), 128'(exp_rdy));
            if (win >= 0) begin
                if (dt_q[win].size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL data_sb: bank %0d granted with no pending data", win);
                end else begin
                    check("data_payload", 128'(pc_scu_data), 128'(dt_q[win][0]));
                    if (pc_scu_data_rdy) void'(dt_q[win].pop_front());
                end
            end
            if (win >= 0 && pc_scu_data_rdy) begin
                m_dt_cur = -1;
`ifndef RVH_L1D_WB_ARB_FIXED_PRIO_EN
                m_dt_ptr = (win + 1) % N_BANK;
`endif
            end else begin
                m_dt_cur = win;
            end

            tgt = int'(scu_pc_resp[1:0]);
            exp_rdy = '0;
            if (scu_pc_resp_vld) exp_rdy[tgt] = 1'b1;
            check("resp_vld", 128'(bank_resp_vld), 128'(exp_rdy));
            check("resp_rdy", 128'(scu_pc_resp_rdy), 128'(bank_resp_rdy[tgt]));
            check("resp_payload", 128'(bank_resp), 128'(scu_pc_resp));
            if (scu_pc_resp_vld && bank_resp_rdy[tgt] && scu_pc_resp[11:8] == WB_ACK) dec_b = tgt;

            if (inc_b != dec_b) begin
                if (inc_b >= 0) m_cnt[inc_b]++;
                if (dec_b >= 0 && m_cnt[dec_b] > 0) m_cnt[dec_b]--;
            end
        end
    end

    // One bus cycle: observe handshakes, then drive the next inputs after the clock edge.
    task automatic cycle(input logic [N_BANK-1:0] ev_want, input logic [N_BANK-1:0] dt_want,
                         input logic ev_rdy, input logic dt_rdy, input bit rsp_want);
        int          b;
        logic [3:0]  rtype;
        @(negedge clk);
        #1;
        ev_hs_obs  = bank_evict_vld & bank_evict_rdy;
        dt_hs_obs  = bank_data_vld & bank_data_rdy;
        rsp_hs_obs = scu_pc_resp_vld & scu_pc_resp_rdy;
        for (int i = 0; i < N_BANK; i++) if (ev_hs_obs[i]) drv_cnt[i]++;
        if (rsp_hs_obs && scu_pc_resp[11:8] == WB_ACK) drv_cnt[scu_pc_resp[1:0]]--;
        @(posedge clk);
        #1;
        for (int i = 0; i < N_BANK; i++) begin
            if (ev_hs_obs[i]) bank_evict_vld[i] = 1'b0;
            if (!bank_evict_vld[i] && ev_want[i]) begin
                bank_evict[i]     = {$urandom, $urandom};
                bank_evict_vld[i] = 1'b1;
                ev_q[i].push_back(bank_evict[i]);
            end
            if (dt_hs_obs[i]) bank_data_vld[i] = 1'b0;
            if (!bank_data_vld[i] && dt_want[i]) begin
                bank_data[i]     = {$urandom, $urandom};
                bank_data_vld[i] = 1'b1;
                dt_q[i].push_back(bank_data[i]);
            end
        end
        if (rsp_hs_obs) scu_pc_resp_vld = 1'b0;
        if (!scu_pc_resp_vld && rsp_want) begin
            b = int'($urandom_range(N_BANK - 1, 0));
            rtype = 4'($urandom_range(15, 0));
            if (drv_cnt[b] > 0 && $urandom_range(3, 0) != 0) rtype = WB_ACK;
            else if (rtype == WB_ACK) rtype = 4'h2;
            scu_pc_resp = $urandom;
            scu_pc_resp[11:8] = rtype;
            scu_pc_resp[2:0]  = {1'($urandom_range(1, 0)), 2'(b)};
            scu_pc_resp_vld   = 1'b1;
        end
        bank_resp_rdy    = 4'($urandom);
        pc_scu_evict_rdy = ev_rdy;
        pc_scu_data_rdy  = dt_rdy;
    endtask

    task automatic drain();
        int left;
        for (int n = 0; n < 400; n++) begin
            left = 0;
            for (int i = 0; i < N_BANK; i++) left += drv_cnt[i];
            if (left == 0 && bank_evict_vld == '0 && bank_data_vld == '0 && !scu_pc_resp_vld) break;
            cycle('0, '0, 1'b1, 1'b1, left != 0);
        end
        left = 0;
        for (int i = 0; i < N_BANK; i++) left += drv_cnt[i];
        check("drain_outstanding", 128'(left), 128'(0));
    endtask

    initial begin
        rst = 1'b0;
        bank_evict_vld   = '0;
        bank_evict       = '0;
        bank_data_vld    = '0;
        bank_data        = '0;
        bank_resp_rdy    = '0;
        pc_scu_evict_rdy = 1'b0;
        pc_scu_data_rdy  = 1'b0;
        scu_pc_resp_vld  = 1'b0;
        scu_pc_resp      = '0;
        for (int i = 0; i < N_BANK; i++) begin
            m_cnt[i]   = 0;
            drv_cnt[i] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_evict_vld", 128'(pc_scu_evict_vld), 128'(0));
        check("reset_data_vld", 128'(pc_scu_data_vld), 128'(0));
        check("reset_resp_vld", 128'(bank_resp_vld), 128'(0));
        check("reset_resp_rdy", 128'(scu_pc_resp_rdy), 128'(0));
        check("reset_outstanding", 128'(outstanding), 128'(0));
        @(posedge clk);
        #1;
        rst    = 1'b1;
        mon_en = 1'b1;

        // All banks request with the channel always ready.
        repeat (5) cycle(4'hF, '0, 1'b1, 1'b0, 1'b0);
        drain();

        // Bank 1 stalls on a busy channel while bank 0 joins.
        cycle(4'b0010, '0, 1'b0, 1'b0, 1'b0);
        cycle(4'b0011, '0, 1'b0, 1'b0, 1'b0);
        cycle(4'b1101, '0, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle(4'b1101, '0, 1'b1, 1'b0, 1'b0);
        drain();

        // Bank 2 fills its outstanding budget before acks arrive.
        repeat (6) cycle(4'b0100, '0, 1'b1, 1'b0, 1'b0);
        drain();

        // Data from banks 0 and 3 with a toggling ready.
        for (int n = 0; n < 8; n++) cycle(4'b0000, 4'b1001, 1'b0, n[0], 1'b0);
        drain();

        for (int n = 0; n < 1500; n++) begin
            cycle(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), $urandom_range(2, 0) != 0);
        end
        drain();

        @(negedge clk);
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
